fifo_param: RTL and testbench

Parametrised synchronous FIFO, the next generation of the team's fixed 16-bit × 8-entry FIFO. Data width, depth and almost-full/almost-empty thresholds are set by parameters. A word-count output and a synchronous flush are added. It sits between producer and consumer blocks in a single clock domain. It uses the same registered-read interface and the same one-cycle OVER/UNDER error pulses as its predecessor.

---
 rtl/fifo_param.sv | 139 +++++++++++++
 tb/tb_fifo_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// fifo_param -- parametrised single-clock FIFO with registered read.
//
// Purpose: buffers DWIDTH-bit words between a producer and a consumer that
// share clock CLK. Depth is 2**AWIDTH. The flags and COUNT are all registered
// and always describe the same stored-word count. Rejected requests raise
// one-cycle error pulses.
//
// Ports:
//   CLK          clock, rising edge
//   RST          synchronous active-high reset
//   CLR          synchronous flush (DOUT is left untouched)
//   WR / DIN     write request and write data
//   RD           read request
//   DOUT         registered read data; holds its value when no read is accepted
//   VALID        DOUT carries a word read at the last edge
//   COUNT        number of stored words, 0..depth
//   FULL         COUNT == depth
//   almostFULL   COUNT >= AF_LEVEL
//   EMPTY        COUNT == 0
//   almostEMPTY  COUNT <= AE_LEVEL
//   OVER         one-cycle pulse: a write was rejected because the FIFO was full
//   UNDER        one-cycle pulse: a read was rejected because the FIFO was empty
module fifo_param #(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              WR,
  input  logic              RD,
  input  logic [DWIDTH-1:0] DIN,
  output logic [DWIDTH-1:0] DOUT,
  output logic              VALID,
  output logic [AWIDTH:0]   COUNT,
  output logic              FULL,
  output logic              almostFULL,
  output logic              EMPTY,
  output logic              almostEMPTY,
  output logic              OVER,
  output logic              UNDER
);

  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(AF_LEVEL);
  localparam logic [AWIDTH:0] AE_C    = (AWIDTH+1)'(AE_LEVEL);

  // Storage has no reset so that it maps onto block RAM.
  logic [DWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH-1:0] wptr_reg, wptr_next;
  logic [AWIDTH-1:0] rptr_reg, rptr_next;
  logic [AWIDTH:0]   count_reg, count_next;
  logic [DWIDTH-1:0] dout_reg;
  logic              valid_reg, over_reg, under_reg;
  logic              full_reg, afull_reg, empty_reg, aempty_reg;
  logic              wr_acc, rd_acc;

  // Acceptance uses only the registered flags. A same-cycle read never makes
  // room for a write, and a same-cycle write never feeds a read. A flush or
  // reset cycle accepts nothing.
  always_comb begin
    wr_acc = WR && !full_reg  && !CLR && !RST;
    rd_acc = RD && !empty_reg && !CLR && !RST;
  end

  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    count_next = count_reg;
    if (CLR) begin
      wptr_next  = '0;
      rptr_next  = '0;
      count_next = '0;
    end else begin
      // Pointers are exactly AWIDTH bits wide, so incrementing wraps at depth.
      if (wr_acc) wptr_next = wptr_reg + 1'b1;
      if (rd_acc) rptr_next = rptr_reg + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wptr_reg] <= DIN;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_reg <= '0;
    end else if (rd_acc) begin
      dout_reg <= mem[rptr_reg];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_reg   <= '0;
      rptr_reg   <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      afull_reg  <= (AF_LEVEL == 0);
      empty_reg  <= 1'b1;
      aempty_reg <= 1'b1;
      valid_reg  <= 1'b0;
      over_reg   <= 1'b0;
      under_reg  <= 1'b0;
    end else begin
      wptr_reg   <= wptr_next;
      rptr_reg   <= rptr_next;
      count_reg  <= count_next;
      // Flags come from the next count, so they never lag COUNT by a cycle.
      full_reg   <= (count_next == DEPTH_C);
      afull_reg  <= (count_next >= AF_C);
      empty_reg  <= (count_next == '0);
      aempty_reg <= (count_next <= AE_C);
      valid_reg  <= rd_acc;
      over_reg   <= WR && full_reg  && !CLR;
      under_reg  <= RD && empty_reg && !CLR;
    end
  end

  assign DOUT        = dout_reg;
  assign VALID       = valid_reg;
  assign COUNT       = count_reg;
  assign FULL        = full_reg;
  assign almostFULL  = afull_reg;
  assign EMPTY       = empty_reg;
  assign almostEMPTY = aempty_reg;
  assign OVER        = over_reg;
  assign UNDER       = under_reg;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param -- self-checking bench for fifo_param (default parameters).
// A queue-based reference model tracks stored words and pulses; every cycle
// all outputs are compared with it. Directed table vectors and hand-written
// sequences add explicit expectations for the corner cases.
module tb_fifo_param;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          CLK = 1'b0;
  logic          RST, CLR, WR, RD;
  logic [DW-1:0] DIN;
  logic [DW-1:0] DOUT;
  logic          VALID;
  logic [AW:0]   COUNT;
  logic          FULL, almostFULL, EMPTY, almostEMPTY, OVER, UNDER;

  fifo_param #(.DWIDTH(DW), .AWIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .WR(WR), .RD(RD), .DIN(DIN),
    .DOUT(DOUT), .VALID(VALID), .COUNT(COUNT), .FULL(FULL),
    .almostFULL(almostFULL), .EMPTY(EMPTY), .almostEMPTY(almostEMPTY),
    .OVER(OVER), .UNDER(UNDER)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_valid = 1'b0, m_over = 1'b0, m_under = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_step(input logic rst, input logic clr, input logic wr,
                            input logic rd, input logic [DW-1:0] din);
    bit was_full, was_empty;
    if (rst) begin
      q.delete();
      m_dout = '0; m_valid = 0; m_over = 0; m_under = 0;
    end else if (clr) begin
      q.delete();
      m_valid = 0; m_over = 0; m_under = 0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_over  = wr && was_full;
      m_under = rd && was_empty;
      m_valid = rd && !was_empty;
      if (m_valid) m_dout = q.pop_front();
      if (wr && !was_full) q.push_back(din);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, ".dout"},   int'(DOUT),        int'(m_dout));
    chk({tag, ".valid"},  int'(VALID),       int'(m_valid));
    chk({tag, ".count"},  int'(COUNT),       n);
    chk({tag, ".full"},   int'(FULL),        int'(n == DEPTH));
    chk({tag, ".afull"},  int'(almostFULL),  int'(n >= AF));
    chk({tag, ".empty"},  int'(EMPTY),       int'(n == 0));
    chk({tag, ".aempty"}, int'(almostEMPTY), int'(n <= AE));
    chk({tag, ".over"},   int'(OVER),        int'(m_over));
    chk({tag, ".under"},  int'(UNDER),       int'(m_under));
  endtask

  // One clock cycle: drive, clock, settle, advance model, compare.
  task automatic step(input string tag, input logic rst, input logic clr,
                      input logic wr, input logic rd, input logic [DW-1:0] din);
    RST = rst; CLR = clr; WR = wr; RD = rd; DIN = din;
    @(posedge CLK);
    #1;
    model_step(rst, clr, wr, rd, din);
    check_model(tag);
    $display("cyc rst=%0b clr=%0b wr=%0b rd=%0b din=%04h -> dout=%04h v=%0b cnt=%0d ov=%0b un=%0b [%s]",
             rst, clr, wr, rd, din, DOUT, VALID, COUNT, OVER, UNDER, tag);
  endtask

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    int            e_count;
    logic          e_valid;
    logic [DW-1:0] e_dout;
    logic          e_over;
    logic          e_under;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [DW-1:0] saved;
    int wp[6] = '{80, 20, 50, 95, 30, 70};
    int rp[6] = '{20, 80, 50, 60, 95, 70};

    // Fill/drain table for the default configuration
    for (int i = 0; i < 8; i++)
      tbl[i] = '{wr:1, rd:0, din:DW'(i+1), e_count:i+1, e_valid:0, e_dout:'0, e_over:0, e_under:0};
    tbl[8] = '{wr:1, rd:0, din:16'h0009, e_count:8, e_valid:0, e_dout:'0, e_over:1, e_under:0};
    for (int j = 0; j < 8; j++)
      tbl[9+j] = '{wr:0, rd:1, din:'0, e_count:7-j, e_valid:1, e_dout:DW'(j+1), e_over:0, e_under:0};
    tbl[17] = '{wr:0, rd:1, din:'0, e_count:0, e_valid:0, e_dout:16'h0008, e_over:0, e_under:1};

    RST = 1; CLR = 0; WR = 0; RD = 0; DIN = '0;

    // Reset state
    step("reset", 1, 0, 0, 0, '0);
    step("reset", 1, 0, 1, 1, 16'hFFFF);
    chk("rst.dout", int'(DOUT), 0);
    chk("rst.count", int'(COUNT), 0);
    chk("rst.empty", int'(EMPTY), 1);
    chk("rst.aempty", int'(almostEMPTY), 1);
    chk("rst.afull", int'(almostFULL), 0);

    // Table: 8 writes, overflow, 8 reads, underflow
    for (int i = 0; i < 18; i++) begin
      step("table", 0, 0, tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk("tbl.count", int'(COUNT), tbl[i].e_count);
      chk("tbl.valid", int'(VALID), int'(tbl[i].e_valid));
      chk("tbl.dout",  int'(DOUT),  int'(tbl[i].e_dout));
      chk("tbl.over",  int'(OVER),  int'(tbl[i].e_over));
      chk("tbl.under", int'(UNDER), int'(tbl[i].e_under));
      chk("tbl.full",  int'(FULL),        int'(tbl[i].e_count == 8));
      chk("tbl.afull", int'(almostFULL),  int'(tbl[i].e_count >= 6));
      chk("tbl.empty", int'(EMPTY),       int'(tbl[i].e_count == 0));
      chk("tbl.aempty", int'(almostEMPTY), int'(tbl[i].e_count <= 1));
    end

    // Wrap: 5 stored, then 20 cycles of simultaneous write and read
    for (int i = 0; i < 5; i++) step("wrap_fill", 0, 0, 1, 0, 16'h0100 + DW'(i));
    for (int k = 0; k < 20; k++) begin
      step("wrap", 0, 0, 1, 1, 16'h0105 + DW'(k));
      chk("wrap.count", int'(COUNT), 5);
      chk("wrap.dout", int'(DOUT), 16'h0100 + k);
      chk("wrap.valid", int'(VALID), 1);
    end
    for (int i = 0; i < 5; i++) step("wrap_drain", 0, 0, 0, 1, '0);
    chk("wrap.last", int'(DOUT), 16'h0100 + 24);

    // Simultaneous requests at FULL
    for (int i = 0; i < 8; i++) step("bfull_fill", 0, 0, 1, 0, 16'h0200 + DW'(i));
    step("bfull", 0, 0, 1, 1, 16'h02FF);
    chk("bfull.over", int'(OVER), 1);
    chk("bfull.count", int'(COUNT), 7);
    chk("bfull.dout", int'(DOUT), 16'h0200);
    for (int i = 0; i < 7; i++) step("bfull_drain", 0, 0, 0, 1, '0);

    // Simultaneous requests at EMPTY
    step("bempty", 0, 0, 1, 1, 16'h0300);
    chk("bempty.under", int'(UNDER), 1);
    chk("bempty.count", int'(COUNT), 1);
    chk("bempty.valid", int'(VALID), 0);

    // Flush with 4 stored and WR=RD=1
    for (int i = 1; i < 4; i++) step("clr_fill", 0, 0, 1, 0, 16'h0300 + DW'(i));
    saved = m_dout;
    step("clr", 0, 1, 1, 1, 16'hDEAD);
    chk("clr.count", int'(COUNT), 0);
    chk("clr.empty", int'(EMPTY), 1);
    chk("clr.valid", int'(VALID), 0);
    chk("clr.over",  int'(OVER), 0);
    chk("clr.under", int'(UNDER), 0);
    chk("clr.dout",  int'(DOUT), int'(saved));
    step("clr_wr", 0, 0, 1, 0, 16'hBEEF);
    step("clr_rd", 0, 0, 0, 1, '0);
    chk("clr.newdata", int'(DOUT), 16'hBEEF);
    chk("clr.newvalid", int'(VALID), 1);

    // Reset mid-stream with COUNT=3 and VALID=1
    for (int i = 0; i < 4; i++) step("rst_fill", 0, 0, 1, 0, 16'h0400 + DW'(i));
    step("rst_rd", 0, 0, 0, 1, '0);
    chk("mid.count", int'(COUNT), 3);
    chk("mid.valid", int'(VALID), 1);
    step("midrst", 1, 0, 1, 1, 16'h0555);
    chk("midrst.dout", int'(DOUT), 0);
    chk("midrst.valid", int'(VALID), 0);
    chk("midrst.count", int'(COUNT), 0);
    chk("midrst.full", int'(FULL), 0);
    chk("midrst.afull", int'(almostFULL), 0);
    chk("midrst.empty", int'(EMPTY), 1);
    chk("midrst.aempty", int'(almostEMPTY), 1);
    chk("midrst.over", int'(OVER), 0);
    chk("midrst.under", int'(UNDER), 0);

    // Randomized traffic with varying bias against the model
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 400; c++) begin
        logic r_wr, r_rd, r_clr, r_rst;
        r_wr  = ($urandom_range(0, 99) < wp[s]);
        r_rd  = ($urandom_range(0, 99) < rp[s]);
        r_clr = ($urandom_range(0, 63) == 0);
        r_rst = ($urandom_range(0, 255) == 0);
        step("rand", r_rst, r_clr, r_wr, r_rd, DW'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
